// File: rtl/ram2e_dram_sched.sv
// RAM2E DRAM slot scheduler: one winner per memory slot among video, CPU, aux
// and refresh, with registered nRAS/nCAS/nRWE sequencing and address select.
module ram2e_dram_sched #(
  parameter int unsigned TRCD         = 2,
  parameter int unsigned TCAS         = 2,
  parameter int unsigned TRP          = 2,
  parameter int unsigned REF_INTERVAL = 13,
  parameter int unsigned AUX_MAX_WAIT = 4
) (
  input  logic       C14M,
  input  logic       nRST,
  input  logic       SLOT,
  input  logic       VID_REQ,
  input  logic       CPU_REQ,
  input  logic       CPU_WR,
  input  logic [3:0] CPU_BANK,
  input  logic       AUX_REQ,
  input  logic       AUX_WR,
  input  logic [3:0] AUX_BANK,
  output logic       nRAS,
  output logic       nCAS,
  output logic       nRWE,
  output logic [1:0] RA_SEL,
  output logic [3:0] RA_BANK,
  output logic [7:0] REF_ROW,
  output logic       VID_GNT,
  output logic       CPU_GNT,
  output logic       AUX_GNT,
  output logic       REF_ACT,
  output logic       DATA_LATCH,
  output logic       VID_MISS,
  output logic       SLOT_OVR
);

  localparam int unsigned PW = 4;
  localparam int unsigned AW = 3;

  typedef enum logic [2:0] {S_IDLE, S_ROW, S_COL, S_RREF, S_PRE} state_t;
  typedef enum logic [1:0] {W_VID, W_CPU, W_AUX, W_REF} win_t;

  state_t          state, state_d;
  win_t            win, win_d;
  logic [PW-1:0]   cnt, cnt_d;
  logic            win_wr, win_wr_d;
  logic [3:0]      win_bank, win_bank_d;
  logic [3:0]      ref_cnt, ref_cnt_d;
  logic [AW-1:0]   aux_wait, aux_wait_d;
  logic            deferred, deferred_d;
  logic            aux_win;
  logic            ref_due, aux_urgent;

  logic            nras_d, ncas_d, nrwe_d;
  logic [1:0]      ra_sel_d;
  logic [3:0]      ra_bank_d;
  logic [7:0]      ref_row_d;
  logic            vid_gnt_d, cpu_gnt_d, aux_gnt_d, ref_act_d;
  logic            data_latch_d, vid_miss_d, slot_ovr_d;

  assign ref_due    = ref_cnt >= 4'(REF_INTERVAL);
  assign aux_urgent = aux_wait >= AW'(AUX_MAX_WAIT);

  // Pin outputs are decoded from the pre-edge state, so strobes lag the FSM by one edge.
  always_comb begin
    state_d      = state;
    win_d        = win;
    cnt_d        = cnt;
    win_wr_d     = win_wr;
    win_bank_d   = win_bank;
    ref_cnt_d    = ref_cnt;
    aux_wait_d   = aux_wait;
    deferred_d   = deferred;
    aux_win      = 1'b0;
    nras_d       = 1'b1;
    ncas_d       = 1'b1;
    nrwe_d       = 1'b1;
    ra_sel_d     = 2'b00;
    ra_bank_d    = 4'h0;
    ref_row_d    = REF_ROW;
    vid_gnt_d    = 1'b0;
    cpu_gnt_d    = 1'b0;
    aux_gnt_d    = 1'b0;
    ref_act_d    = 1'b0;
    data_latch_d = 1'b0;
    vid_miss_d   = 1'b0;
    slot_ovr_d   = SLOT && (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (SLOT) begin
          if (ref_cnt != 4'hF) ref_cnt_d = ref_cnt + 4'd1;
          cnt_d      = '0;
          state_d    = S_ROW;
          win_wr_d   = 1'b0;
          win_bank_d = 4'h0;
          if (ref_due && deferred) begin
            win_d      = W_REF;
            state_d    = S_RREF;
            vid_miss_d = VID_REQ;
          end else if (VID_REQ) begin
            win_d = W_VID;
            if (ref_due) deferred_d = 1'b1;
          end else if (ref_due) begin
            win_d   = W_REF;
            state_d = S_RREF;
          end else if (AUX_REQ && aux_urgent) begin
            win_d      = W_AUX;
            win_wr_d   = AUX_WR;
            win_bank_d = AUX_BANK;
            aux_win    = 1'b1;
          end else if (CPU_REQ) begin
            win_d      = W_CPU;
            win_wr_d   = CPU_WR;
            win_bank_d = CPU_BANK;
          end else if (AUX_REQ) begin
            win_d      = W_AUX;
            win_wr_d   = AUX_WR;
            win_bank_d = AUX_BANK;
            aux_win    = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
          // Aux starvation counter only moves on arbitrated slots.
          if (aux_win || !AUX_REQ) aux_wait_d = '0;
          else if (aux_wait != {AW{1'b1}}) aux_wait_d = aux_wait + AW'(1);
        end
      end
      S_ROW: begin
        nras_d    = 1'b0;
        ra_bank_d = win_bank;
        if (cnt == '0) begin
          vid_gnt_d = (win == W_VID);
          cpu_gnt_d = (win == W_CPU);
          aux_gnt_d = (win == W_AUX);
        end
        if (cnt == PW'(TRCD - 1)) begin
          state_d = S_COL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + PW'(1);
        end
      end
      S_COL: begin
        nras_d    = 1'b0;
        ncas_d    = 1'b0;
        nrwe_d    = ~win_wr;
        ra_sel_d  = 2'b01;
        ra_bank_d = win_bank;
        if (cnt == PW'(TCAS - 1)) begin
          data_latch_d = ~win_wr;
          state_d      = S_PRE;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt + PW'(1);
        end
      end
      S_RREF: begin
        nras_d    = 1'b0;
        ra_sel_d  = 2'b10;
        ref_act_d = (cnt == '0);
        if (cnt == PW'(TRCD + TCAS - 1)) begin
          state_d = S_PRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + PW'(1);
        end
      end
      S_PRE: begin
        ra_bank_d = win_bank;
        if (cnt == PW'(TRP - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (win == W_REF) begin
            ref_cnt_d  = 4'h0;
            deferred_d = 1'b0;
            ref_row_d  = REF_ROW + 8'd1;
          end
        end else begin
          cnt_d = cnt + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge C14M or negedge nRST) begin
    if (!nRST) begin
      state      <= S_IDLE;
      win        <= W_VID;
      cnt        <= '0;
      win_wr     <= 1'b0;
      win_bank   <= 4'h0;
      ref_cnt    <= 4'h0;
      aux_wait   <= '0;
      deferred   <= 1'b0;
      nRAS       <= 1'b1;
      nCAS       <= 1'b1;
      nRWE       <= 1'b1;
      RA_SEL     <= 2'b00;
      RA_BANK    <= 4'h0;
      REF_ROW    <= 8'h00;
      VID_GNT    <= 1'b0;
      CPU_GNT    <= 1'b0;
      AUX_GNT    <= 1'b0;
      REF_ACT    <= 1'b0;
      DATA_LATCH <= 1'b0;
      VID_MISS   <= 1'b0;
      SLOT_OVR   <= 1'b0;
    end else begin
      state      <= state_d;
      win        <= win_d;
      cnt        <= cnt_d;
      win_wr     <= win_wr_d;
      win_bank   <= win_bank_d;
      ref_cnt    <= ref_cnt_d;
      aux_wait   <= aux_wait_d;
      deferred   <= deferred_d;
      nRAS       <= nras_d;
      nCAS       <= ncas_d;
      nRWE       <= nrwe_d;
      RA_SEL     <= ra_sel_d;
      RA_BANK    <= ra_bank_d;
      REF_ROW    <= ref_row_d;
      VID_GNT    <= vid_gnt_d;
      CPU_GNT    <= cpu_gnt_d;
      AUX_GNT    <= aux_gnt_d;
      REF_ACT    <= ref_act_d;
      DATA_LATCH <= data_latch_d;
      VID_MISS   <= vid_miss_d;
      SLOT_OVR   <= slot_ovr_d;
    end
  end

endmodule

// File: tb/tb_ram2e_dram_sched.sv
// Directed bench for ram2e_dram_sched: per-edge strobe/grant expectations per slot.
module tb_ram2e_dram_sched;

  logic       C14M = 1'b0;
  logic       nRST;
  logic       SLOT, VID_REQ, CPU_REQ, CPU_WR, AUX_REQ, AUX_WR;
  logic [3:0] CPU_BANK, AUX_BANK;
  logic       nRAS, nCAS, nRWE;
  logic [1:0] RA_SEL;
  logic [3:0] RA_BANK;
  logic [7:0] REF_ROW;
  logic       VID_GNT, CPU_GNT, AUX_GNT, REF_ACT, DATA_LATCH, VID_MISS, SLOT_OVR;

  int checks = 0;
  int errors = 0;

  localparam int K_NONE = 0;
  localparam int K_VID  = 1;
  localparam int K_CPU  = 2;
  localparam int K_AUX  = 3;
  localparam int K_REF  = 4;

  ram2e_dram_sched dut (
    .C14M(C14M), .nRST(nRST), .SLOT(SLOT),
    .VID_REQ(VID_REQ), .CPU_REQ(CPU_REQ), .CPU_WR(CPU_WR), .CPU_BANK(CPU_BANK),
    .AUX_REQ(AUX_REQ), .AUX_WR(AUX_WR), .AUX_BANK(AUX_BANK),
    .nRAS(nRAS), .nCAS(nCAS), .nRWE(nRWE), .RA_SEL(RA_SEL), .RA_BANK(RA_BANK),
    .REF_ROW(REF_ROW), .VID_GNT(VID_GNT), .CPU_GNT(CPU_GNT), .AUX_GNT(AUX_GNT),
    .REF_ACT(REF_ACT), .DATA_LATCH(DATA_LATCH), .VID_MISS(VID_MISS), .SLOT_OVR(SLOT_OVR)
  );

  always #5 C14M = ~C14M;

  task automatic tick();
    @(posedge C14M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one slot (edge 0) and checks edges 0..7 against the expected winner.
  task automatic run_slot(input string name,
                          input logic vid, input logic cpu, input logic cwr, input logic [3:0] cbank,
                          input logic aux, input logic awr, input logic [3:0] abank,
                          input int kind, input logic [3:0] xbank, input logic xwr,
                          input int n_miss, input int ovr_at, input int n_ovr,
                          input logic [7:0] row0, input logic [7:0] row7);
    int   miss_seen, ovr_seen;
    logic in_row, in_col, busy, mem;
    logic [1:0] sel;
    miss_seen = 0;
    ovr_seen  = 0;
    mem       = (kind == K_VID) || (kind == K_CPU) || (kind == K_AUX);
    SLOT = 1'b1; VID_REQ = vid; CPU_REQ = cpu; CPU_WR = cwr; CPU_BANK = cbank;
    AUX_REQ = aux; AUX_WR = awr; AUX_BANK = abank;
    for (int e = 0; e <= 7; e++) begin
      if (e > 0) SLOT = (e == ovr_at);
      tick();
      if (e == 0) begin
        // Requests are only sampled at edge 0; scramble them for the rest of the access.
        VID_REQ = 1'b1; CPU_REQ = 1'b1; AUX_REQ = 1'b1;
        CPU_WR = ~cwr; AUX_WR = ~awr; CPU_BANK = ~cbank; AUX_BANK = ~abank;
      end
      in_row = (kind != K_NONE) && (e >= 1) && (e <= 4);
      in_col = mem && (e >= 3) && (e <= 4);
      busy   = (kind != K_NONE) && (e >= 1) && (e <= 6);
      sel    = (kind == K_REF && in_row) ? 2'b10 : (in_col ? 2'b01 : 2'b00);
      chk($sformatf("%s nRAS e%0d", name, e), 32'(nRAS), 32'(!in_row));
      chk($sformatf("%s nCAS e%0d", name, e), 32'(nCAS), 32'(!in_col));
      chk($sformatf("%s nRWE e%0d", name, e), 32'(nRWE), 32'(!(in_col && xwr)));
      chk($sformatf("%s RA_SEL e%0d", name, e), 32'(RA_SEL), 32'(sel));
      chk($sformatf("%s RA_BANK e%0d", name, e), 32'(RA_BANK), 32'(busy ? xbank : 4'h0));
      chk($sformatf("%s DATA_LATCH e%0d", name, e), 32'(DATA_LATCH), 32'(in_col && !xwr && e == 4));
      chk($sformatf("%s VID_GNT e%0d", name, e), 32'(VID_GNT), 32'(kind == K_VID && e == 1));
      chk($sformatf("%s CPU_GNT e%0d", name, e), 32'(CPU_GNT), 32'(kind == K_CPU && e == 1));
      chk($sformatf("%s AUX_GNT e%0d", name, e), 32'(AUX_GNT), 32'(kind == K_AUX && e == 1));
      chk($sformatf("%s REF_ACT e%0d", name, e), 32'(REF_ACT), 32'(kind == K_REF && e == 1));
      if (e == 0) chk($sformatf("%s REF_ROW start", name), 32'(REF_ROW), 32'(row0));
      if (e == 7) chk($sformatf("%s REF_ROW end", name), 32'(REF_ROW), 32'(row7));
      miss_seen += int'(VID_MISS);
      ovr_seen  += int'(SLOT_OVR);
    end
    SLOT = 1'b0;
    chk($sformatf("%s VID_MISS count", name), 32'(miss_seen), 32'(n_miss));
    chk($sformatf("%s SLOT_OVR count", name), 32'(ovr_seen), 32'(n_ovr));
  endtask

  initial begin
    nRST = 1'b0; SLOT = 1'b0; VID_REQ = 1'b0; CPU_REQ = 1'b0; CPU_WR = 1'b0;
    AUX_REQ = 1'b0; AUX_WR = 1'b0; CPU_BANK = 4'h0; AUX_BANK = 4'h0;
    tick();
    tick();
    chk("rst nRAS", 32'(nRAS), 32'd1);
    chk("rst nCAS", 32'(nCAS), 32'd1);
    chk("rst nRWE", 32'(nRWE), 32'd1);
    chk("rst RA_SEL", 32'(RA_SEL), 32'd0);
    chk("rst RA_BANK", 32'(RA_BANK), 32'd0);
    chk("rst REF_ROW", 32'(REF_ROW), 32'd0);
    chk("rst pulses", 32'({VID_GNT, CPU_GNT, AUX_GNT, REF_ACT, DATA_LATCH, VID_MISS, SLOT_OVR}), 32'd0);
    nRST = 1'b1;
    tick();

    // CPU read then write (ref_cnt 1, 2)
    run_slot("cpu_rd", 0, 1, 0, 4'h5, 0, 0, 4'h0, K_CPU, 4'h5, 0, 0, 0, 0, 8'd0, 8'd0);
    run_slot("cpu_wr", 0, 1, 1, 4'h3, 0, 0, 4'h0, K_CPU, 4'h3, 1, 0, 0, 0, 8'd0, 8'd0);

    // CPU vs AUX contention: CPU wins four, AUX wins fifth, then counter is clear (ref_cnt 8)
    for (int i = 0; i < 4; i++)
      run_slot($sformatf("arb%0d", i), 0, 1, 0, 4'h2, 1, 1, 4'h9, K_CPU, 4'h2, 0, 0, 0, 0, 8'd0, 8'd0);
    run_slot("arb_aux", 0, 1, 0, 4'h2, 1, 1, 4'h9, K_AUX, 4'h9, 1, 0, 0, 0, 8'd0, 8'd0);
    run_slot("arb_after", 0, 1, 0, 4'h2, 1, 1, 4'h9, K_CPU, 4'h2, 0, 0, 0, 0, 8'd0, 8'd0);

    // Second SLOT three cycles into a read is ignored (ref_cnt 9)
    run_slot("ovr", 0, 1, 0, 4'hC, 0, 0, 4'h0, K_CPU, 4'hC, 0, 0, 3, 1, 8'd0, 8'd0);

    // Empty slots bring ref_cnt to 13 without a refresh yet
    for (int i = 0; i < 4; i++)
      run_slot($sformatf("empty%0d", i), 0, 0, 0, 4'h0, 0, 0, 4'h0, K_NONE, 4'h0, 0, 0, 0, 0, 8'd0, 8'd0);

    // Refresh due but video wins and defers it; the next video slot is lost to refresh
    run_slot("vid_defer", 1, 0, 0, 4'h0, 0, 0, 4'h0, K_VID, 4'h0, 0, 0, 0, 0, 8'd0, 8'd0);
    run_slot("forced_ref", 1, 0, 0, 4'h0, 0, 0, 4'h0, K_REF, 4'h0, 0, 1, 0, 0, 8'd0, 8'd1);
    run_slot("vid_after", 1, 0, 0, 4'h0, 0, 0, 4'h0, K_VID, 4'h0, 0, 0, 0, 0, 8'd1, 8'd1);

    // Asynchronous reset during a read's column phase
    SLOT = 1'b1; VID_REQ = 1'b0; CPU_REQ = 1'b1; CPU_WR = 1'b0; CPU_BANK = 4'h5; AUX_REQ = 1'b0;
    tick();
    SLOT = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_rst pre nCAS", 32'(nCAS), 32'd0);
    nRST = 1'b0;
    #1;
    chk("mid_rst nRAS", 32'(nRAS), 32'd1);
    chk("mid_rst nCAS", 32'(nCAS), 32'd1);
    chk("mid_rst RA_BANK", 32'(RA_BANK), 32'd0);
    chk("mid_rst REF_ROW", 32'(REF_ROW), 32'd0);
    tick();
    tick();
    nRST = 1'b1;
    tick();
    run_slot("post_rst", 0, 0, 0, 4'h0, 1, 0, 4'h7, K_AUX, 4'h7, 0, 0, 0, 0, 8'd0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram2e_dram_sched.md
Name: ram2e_dram_sched

Overview:
Per-slot DRAM access scheduler for the RAM2E card. It shares the card's DRAM between four users: 80-column video fetch, 6502 CPU access, an auxiliary port (bank-register loader / RAM test), and refresh. Once per memory slot it selects a single winner and generates the nRAS/nCAS/nRWE sequence, row/column/refresh address select, bank bits and a data-latch strobe. It sits between the Apple II timing decode (PHI1-edge slot pulse) and the DRAM pins.

Parameters:
TRCD, 2, C14M cycles nRAS low before nCAS falls (ROW phase length)
TCAS, 2, C14M cycles nCAS low (COL phase length)
TRP, 2, C14M cycles precharge with nRAS/nCAS high
REF_INTERVAL, 13, slots between required refreshes (4-bit counter)
AUX_MAX_WAIT, 4, consecutive lost slots after which AUX beats CPU

Ports:
C14M  in  1  14.318 MHz clock; all state changes on rising edge
nRST  in  1  asynchronous active-low reset
SLOT  in  1  one-cycle pulse marking the start of a memory slot
VID_REQ  in  1  video fetch wanted this slot
CPU_REQ  in  1  CPU access wanted this slot
CPU_WR  in  1  CPU access is a write
CPU_BANK  in  4  CPU bank bits to RA[11:8]
AUX_REQ  in  1  auxiliary access wanted
AUX_WR  in  1  auxiliary access is a write
AUX_BANK  in  4  auxiliary bank bits
nRAS  out  1  DRAM row strobe
nCAS  out  1  DRAM column strobe
nRWE  out  1  DRAM write enable
RA_SEL  out  2  address mux: 00 row, 01 column, 10 refresh row
RA_BANK  out  4  bank bits for current access
REF_ROW  out  8  refresh row counter
VID_GNT, CPU_GNT, AUX_GNT, REF_ACT  out  1 each  one-cycle grant pulses
DATA_LATCH  out  1  one-cycle strobe, read data valid
VID_MISS  out  1  one-cycle pulse: video lost slot to forced refresh
SLOT_OVR  out  1  one-cycle pulse: SLOT arrived while busy

Behaviour:
- Reset: nRAS=nCAS=nRWE=1, RA_SEL=00, RA_BANK=0, REF_ROW=0, all pulses 0, ref_cnt=0, aux_wait=0, deferred=0, FSM=IDLE.
- All outputs registered. FSM: IDLE -> ROW(TRCD) -> COL(TCAS) -> PRE(TRP) -> IDLE. Refresh: IDLE -> ROW(TRCD+TCAS, nCAS high, RA_SEL=10) -> PRE(TRP).
- Edge where SLOT=1 in IDLE is "edge 0": winner latched, ref_cnt increments (saturating at 15). Edges 1..TRCD: ROW, nRAS=0, RA_SEL=00. Next TCAS edges: COL, nCAS=0, RA_SEL=01, nRWE=0 only if write. Then TRP edges PRE, strobes high, RA_SEL=00. Back to IDLE after edge 1+TRCD+TCAS+TRP-1 (7 cycles with defaults).
- GNT/REF_ACT pulse at edge 1. DATA_LATCH pulses on the last COL cycle, reads only.
- RA_BANK = winner's bank (VID: 0) from edge 1 until IDLE; 0 in IDLE.
- Arbitration at edge 0, ref_due = (ref_cnt >= REF_INTERVAL):
  1. ref_due & deferred -> refresh; VID_MISS pulses if VID_REQ.
  2. VID_REQ -> video; if ref_due, set deferred.
  3. ref_due -> refresh.
  4. AUX_REQ & aux_wait >= AUX_MAX_WAIT -> AUX.
  5. CPU_REQ -> CPU.
  6. AUX_REQ -> AUX.
  7. Otherwise no access; FSM stays IDLE.
- Refresh completion clears ref_cnt and deferred. REF_ROW increments (mod 256) at the end of refresh PRE.
- aux_wait: increments (saturating) each slot AUX_REQ loses. Clears on AUX grant or slot with AUX_REQ=0.
- SLOT while not IDLE: ignored (no arbitration, no ref_cnt change); SLOT_OVR pulses next edge.
- Requests are sampled only at edge 0; changes mid-access have no effect.
- nRST low mid-access: strobes go high immediately (async), FSM returns to IDLE.

Test Plan:
- Reset, SLOT with CPU_REQ=1, CPU_WR=0, CPU_BANK=5 -> nRAS low edges 1-4, nCAS low edges 3-4, DATA_LATCH edge 4, RA_BANK=5, nRWE=1, idle by edge 7.
- CPU_WR=1 -> nRWE low exactly edges 3-4, no DATA_LATCH.
- 13 empty slots, then slot with VID_REQ -> video granted, deferred set. Next slot with VID_REQ -> REF_ACT, VID_MISS, nCAS stays high, REF_ROW 0->1.
- CPU_REQ and AUX_REQ held 5 slots -> CPU wins 4 slots, AUX wins 5th with AUX_BANK on RA_BANK, aux_wait cleared.
- SLOT pulses 3 cycles apart -> second ignored, SLOT_OVR=1 once, first access completes unchanged.
- nRST asserted at edge 3 of a read -> nRAS=nCAS=1 immediately. After release, next SLOT arbitrates normally.
